// File: rtl/mult_div_sequencer_pkg.sv
// mult_div_sequencer_pkg
//   Shared definitions for the multiply/divide sequencer.
//   Contents: default widths, the most-negative operand constant,
//   the FSM state encoding and the operation select.
package mult_div_sequencer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  // Most-negative value at the default width; narrower builds take the top slice.
  localparam logic [DEF_WIDTH-1:0] MIN_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } mdc_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } mdc_op_e;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// mult_div_sequencer_if
//   Pipeline-side bundle for the multiply/divide sequencer.
//   master : execute stage (drives ctrl_mult, ctrl_div, operand_a, operand_b)
//   slave  : sequencer     (drives result, exception, result_rdy, busy)
interface mult_div_sequencer_if
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             result_rdy;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, operand_a, operand_b,
    input  result, exception, result_rdy, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, operand_a, operand_b,
    output result, exception, result_rdy, busy
  );

endinterface

// File: rtl/mdc_step_counter.sv
// mdc_step_counter
//   Iteration counter for the multiply/divide sequencer.
//   Ports: clock, clr_n (async active-low reset), clr (sync clear, wins over en),
//          en (count up by one), tc (high while count == WIDTH-1).
module mdc_step_counter
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clock,
  input  logic clr_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
//   Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring)
//   unit, one iteration per clock, WIDTH+2 cycles from start to result_rdy.
//   Ports: clock, clr_n (async active-low reset), bus (slave modport:
//          ctrl_mult/ctrl_div/operand_a/operand_b in;
//          result/exception/result_rdy/busy out).
//   Build option: MDC_EARLY_OUT_EN -- a multiply with a zero operand or a
//   divide by zero leaves the iteration state after its first cycle, giving
//   result_rdy three cycles after the start sample with unchanged values.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | waiting for ctrl_mult / ctrl_div; operands latched on start
//   ST_MULT  | Booth iteration, one multiplier bit per clock
//   ST_DIV   | non-restoring iteration, one quotient bit per clock
//   ST_FIXUP | sign fix, overflow / divide-by-zero, register result
//   ST_DONE  | result_rdy strobe, then back to idle
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                 clock,
  input logic                 clr_n,
  mult_div_sequencer_if.slave bus
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_NEG_W = MIN_NEG[DEF_WIDTH-1 -: WIDTH];

  mdc_state_e state_q, state_d;
  mdc_op_e    op_q, op_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             early_q, early_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic start, tc, cnt_clr, cnt_en, busy_o, rdy_o;

  logic [WIDTH-1:0]   a_mag, b_mag, upper;
  logic [WIDTH:0]     booth_sum, rem_sh, rem_nx;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     prod_top;

  mdc_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clock (clock),
    .clr_n (clr_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  // State register
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_mult) begin
          state_d = ST_MULT;
        end else if (bus.ctrl_div) begin
          state_d = ST_DIV;
        end
      end
      ST_MULT, ST_DIV: begin
        if (tc || early_q) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start   = (state_q == ST_IDLE) && (bus.ctrl_mult || bus.ctrl_div);
    cnt_clr = start;
    cnt_en  = (state_q == ST_MULT) || (state_q == ST_DIV);
    busy_o  = (state_q == ST_MULT) || (state_q == ST_DIV) || (state_q == ST_FIXUP);
    rdy_o   = (state_q == ST_DONE);
  end

  // Datapath next values
  always_comb begin
    op_d     = op_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    early_d  = early_q;
    result_d = result_q;
    exc_d    = exc_q;

    a_mag = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    b_mag = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

    // Booth add/sub done one bit wider so a most-negative multiplicand
    // cannot wrap before the arithmetic shift.
    upper = prod_q[PW-1:WIDTH+1];
    case (prod_q[1:0])
      2'b01:   booth_sum = {upper[WIDTH-1], upper} + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   booth_sum = {upper[WIDTH-1], upper} - {mcand_q[WIDTH-1], mcand_q};
      default: booth_sum = {upper[WIDTH-1], upper};
    endcase

    // Remainder stays within [-divisor, divisor) after each step, so the
    // WIDTH+1-bit wrap of the shifted value is harmless.
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_nx = rem_q[WIDTH] ? (rem_sh + {1'b0, dvs_q}) : (rem_sh - {1'b0, dvs_q});

    product  = prod_q[PW-1:1];
    prod_top = product[2*WIDTH-1:WIDTH-1];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = bus.ctrl_mult ? OP_MUL : OP_DIV;
          mcand_d = bus.operand_a;
          prod_d  = {{WIDTH{1'b0}}, bus.operand_b, 1'b0};
          dvs_d   = b_mag;
          quo_d   = a_mag;
          rem_d   = '0;
          neg_d   = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
          dz_d    = (bus.operand_b == '0);
          ovf_d   = (bus.operand_a == MIN_NEG_W) && (bus.operand_b == '1);
`ifdef MDC_EARLY_OUT_EN
          early_d = bus.ctrl_mult ? ((bus.operand_a == '0) || (bus.operand_b == '0))
                                  : (bus.operand_b == '0);
`else
          early_d = 1'b0;
`endif
        end
      end
      ST_MULT: begin
        prod_d = {booth_sum, prod_q[WIDTH:1]};
      end
      ST_DIV: begin
        rem_d = rem_nx;
        quo_d = {quo_q[WIDTH-2:0], ~rem_nx[WIDTH]};
      end
      ST_FIXUP: begin
        if (op_q == OP_MUL) begin
          if (early_q) begin
            // Product register is only one step in; the answer is known zero.
            result_d = '0;
            exc_d    = 1'b0;
          end else begin
            result_d = product[WIDTH-1:0];
            exc_d    = !((&prod_top) || (~|prod_top));
          end
        end else if (dz_q) begin
          result_d = '0;
          exc_d    = 1'b1;
        end else if (ovf_q) begin
          result_d = MIN_NEG_W;
          exc_d    = 1'b1;
        end else begin
          result_d = neg_q ? -quo_q : quo_q;
          exc_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      prod_q   <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      early_q  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      early_q  <= early_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.result     = result_q;
  assign bus.exception  = exc_q;
  assign bus.result_rdy = rdy_o;
  assign bus.busy       = busy_o;

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

`ifdef MDC_EARLY_OUT_EN
  localparam int DZ_LAT = 3;
`else
  localparam int DZ_LAT = 34;
`endif
  localparam int LAT = 34;

  logic clock = 1'b0;
  logic clr_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mult_div_sequencer_if #(.WIDTH(32)) bus ();

  mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // disturb: 0 none, 1 ctrl_div pulse + operand change while busy, 2 ctrl_mult pulse in DONE
  task automatic run_op(input logic do_mul, input logic do_div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat, input int disturb, input string name);
    int lat;
    bit seen;
    int busy_err;
    @(negedge clock);
    bus.ctrl_mult = do_mul;
    bus.ctrl_div  = do_div;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clock);
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    lat = 0;
    seen = 0;
    busy_err = 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      if (n > 1) @(negedge clock);
      if (bus.result_rdy) begin
        seen = 1;
        lat  = n;
      end else if (!bus.busy) begin
        busy_err++;
      end
      if (disturb == 1 && n == 5) begin
        bus.ctrl_div  = 1'b1;
        bus.operand_a = 32'h0000_1234;
        bus.operand_b = 32'h0000_0001;
      end
      if (disturb == 1 && n == 6) begin
        bus.ctrl_div  = 1'b0;
        bus.operand_a = 32'h0;
      end
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, lat, seen, exp_lat);
    end
    checks++;
    if (busy_err != 0) begin
      failures++;
      $display("FAIL %s busy_low_during_op: %0d cycles low, expected 0", name, busy_err);
    end
    checks++;
    if (bus.result !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, bus.result, exp_res);
    end
    checks++;
    if (bus.exception !== exp_exc) begin
      failures++;
      $display("FAIL %s exception: got %b expected %b", name, bus.exception, exp_exc);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_rdy: got %b expected 0", name, bus.busy);
    end
    if (disturb == 2) begin
      bus.ctrl_mult = 1'b1;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd3;
    end
    @(negedge clock);
    bus.ctrl_mult = 1'b0;
    checks++;
    if (bus.result_rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s rdy_one_cycle: got %b expected 0", name, bus.result_rdy);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after_done: busy got %b expected 0", name, bus.busy);
    end
    checks++;
    if (bus.result !== exp_res) begin
      failures++;
      $display("FAIL %s result_hold: got %h expected %h", name, bus.result, exp_res);
    end
  endtask

  task automatic test_reset();
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    #1 clr_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result: got %h expected 00000000", bus.result);
    end
    checks++;
    if (bus.exception !== 1'b0) begin
      failures++;
      $display("FAIL reset_exception: got %b expected 0", bus.exception);
    end
    checks++;
    if (bus.result_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy: got %b expected 0", bus.result_rdy);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    clr_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult();
    run_op(1, 0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT, 0, "mul_7_m3");
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, LAT, 0, "mul_ovf_2p32");
    run_op(1, 0, 32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 1'b0, LAT, 0, "mul_max_x1");
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, LAT, 0, "mul_minneg_sq");
    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, LAT, 0, "mul_m1_m1");
    run_op(1, 0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, LAT, 0, "mul_minneg_x1");
  endtask

  task automatic test_div();
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, LAT, 0, "div_m7_2");
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, LAT, 0, "div_minneg_m1");
    run_op(0, 1, 32'd100,      32'd0,        32'h0000_0000, 1'b1, DZ_LAT, 0, "div_by_zero");
    run_op(0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0, LAT, 0, "div_m100_m7");
    run_op(0, 1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LAT, 0, "div_7_m2");
    run_op(0, 1, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, LAT, 0, "div_minneg_1");
    run_op(0, 1, 32'd5,        32'd7,        32'h0000_0000, 1'b0, LAT, 0, "div_5_7");
  endtask

  task automatic test_abort();
    int rdy_seen;
    @(negedge clock);
    bus.ctrl_mult = 1'b1;
    bus.operand_a = 32'd123;
    bus.operand_b = 32'd456;
    @(negedge clock);
    bus.ctrl_mult = 1'b0;
    repeat (10) @(negedge clock);
    clr_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== 32'h0 || bus.exception !== 1'b0 ||
        bus.result_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: result=%h exc=%b rdy=%b busy=%b expected all 0",
               bus.result, bus.exception, bus.result_rdy, bus.busy);
    end
    rdy_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (n == 3) clr_n = 1'b1;
      if (bus.result_rdy) rdy_seen++;
    end
    checks++;
    if (rdy_seen != 0) begin
      failures++;
      $display("FAIL abort_no_rdy: rdy seen %0d times, expected 0", rdy_seen);
    end
    run_op(1, 0, 32'd5, 32'd6, 32'd30, 1'b0, LAT, 0, "restart_mul_5_6");
  endtask

  task automatic test_back_to_back();
    run_op(0, 1, 32'd100, 32'd7, 32'h0000_000E, 1'b0, LAT, 1, "busy_start_ignored");
    run_op(1, 1, 32'd6,   32'd7, 32'd42,        1'b0, LAT, 0, "both_starts_mul");
    run_op(1, 0, 32'd3,   32'd4, 32'd12,        1'b0, LAT, 2, "start_in_done_ignored");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
